// File: rtl/datapath_monitor.sv
// datapath_monitor: run-time checker for a single shared bus with NUM_DRIVERS
// enabled drivers and an NZP condition-code register. Flags driver
// contention, bus/driver disagreement, NZP update errors and illegal NZP
// encodings. Keeps sticky flags, a saturating count, a first-error record
// and a one-shot interrupt.

// Per-driver compare: the driver is enabled and its data disagrees with the bus.
module datapath_monitor_lane #(
  parameter int WIDTH = 16
) (
  input  logic             ena,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] bus,
  output logic             mis
);
  assign mis = ena & (data != bus);
endmodule

module datapath_monitor #(
  parameter int WIDTH       = 16,
  parameter int NUM_DRIVERS = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mon_en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             bus,
  input  logic [NUM_DRIVERS-1:0]       drv_ena,
  input  logic [NUM_DRIVERS*WIDTH-1:0] drv_data,
  input  logic                         flag_we,
  input  logic                         n,
  input  logic                         z,
  input  logic                         p,
  output logic [3:0]                   err_sticky,
  output logic [CNT_WIDTH-1:0]         err_count,
  output logic                         first_valid,
  output logic [3:0]                   first_code,
  output logic [WIDTH-1:0]             first_bus,
  output logic [NUM_DRIVERS-1:0]       first_ena,
  output logic                         err_irq
);

  logic [NUM_DRIVERS-1:0] lane_mis;
  logic                   ena_multi, ena_one;
  logic [2:0]             nzp, nzp_bus;
  logic                   nzp_multi;
  logic [3:0]             chk;
  logic                   fire;

  // shadow state: expected NZP from the last flag write
  logic [2:0]             exp_nzp;
  logic                   exp_valid;
  logic                   flags_init;
  logic                   fv_d;

  genvar g;
  generate
    for (g = 0; g < NUM_DRIVERS; g++) begin : g_lane
      datapath_monitor_lane #(.WIDTH(WIDTH)) u_lane (
        .ena  (drv_ena[g]),
        .data (drv_data[g*WIDTH +: WIDTH]),
        .bus  (bus),
        .mis  (lane_mis[g])
      );
    end
  endgenerate

  // x & (x-1) clears the lowest set bit, so non-zero means two or more set
  assign ena_multi = |(drv_ena & (drv_ena - NUM_DRIVERS'(1)));
  assign ena_one   = (drv_ena != '0) & ~ena_multi;
  assign nzp       = {n, z, p};
  assign nzp_multi = |(nzp & (nzp - 3'd1));

  // NZP value the register should take when loaded from the bus (signed)
  assign nzp_bus = bus[WIDTH-1] ? 3'b100 : ((bus == '0) ? 3'b010 : 3'b001);

  // Per-check fire vector, all gated by mon_en
  always_comb begin
    chk    = '0;
    chk[0] = mon_en & ena_multi;
    chk[1] = mon_en & ena_one & (|lane_mis);
    chk[2] = mon_en & exp_valid & (nzp != exp_nzp);
    chk[3] = mon_en & (nzp_multi | (flags_init & (nzp == 3'b000)));
  end

  assign fire = |chk;

  // Shadow NZP pipeline: a write is compared on the very next cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_nzp    <= '0;
      exp_valid  <= 1'b0;
      flags_init <= 1'b0;
    end else if (clr) begin
      exp_nzp    <= '0;
      exp_valid  <= 1'b0;
      flags_init <= 1'b0;
    end else if (mon_en & flag_we) begin
      exp_nzp    <= nzp_bus;
      exp_valid  <= 1'b1;
      flags_init <= 1'b1;
    end else begin
      exp_valid  <= 1'b0;
    end
  end

  // Sticky flags, saturating counter and first-error capture; clr wins over fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky  <= '0;
      err_count   <= '0;
      first_valid <= 1'b0;
      first_code  <= '0;
      first_bus   <= '0;
      first_ena   <= '0;
    end else if (clr) begin
      err_sticky  <= '0;
      err_count   <= '0;
      first_valid <= 1'b0;
      first_code  <= '0;
      first_bus   <= '0;
      first_ena   <= '0;
    end else if (fire) begin
      err_sticky <= err_sticky | chk;
      if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
      if (!first_valid) begin
        first_valid <= 1'b1;
        first_code  <= chk;
        first_bus   <= bus;
        first_ena   <= drv_ena;
      end
    end
  end

  // Interrupt: rising edge of first_valid, seen one cycle after it sets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_d    <= 1'b0;
      err_irq <= 1'b0;
    end else if (clr) begin
      fv_d    <= 1'b0;
      err_irq <= 1'b0;
    end else begin
      fv_d    <= first_valid;
      err_irq <= first_valid & ~fv_d;
    end
  end

endmodule

// File: tb/tb_datapath_monitor.sv
// Self-checking bench for datapath_monitor: directed plan plus a randomized
// phase, both scored against a cycle-level behavioural model.
module tb_datapath_monitor;
  localparam int W   = 16;
  localparam int ND  = 4;
  localparam int CW  = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n, mon_en, clr, flag_we, n, z, p;
  logic [W-1:0]    bus;
  logic [ND-1:0]   drv_ena;
  logic [ND*W-1:0] drv_data;
  logic [3:0]      err_sticky, first_code;
  logic [CW-1:0]   err_count;
  logic            first_valid, err_irq;
  logic [W-1:0]    first_bus;
  logic [ND-1:0]   first_ena;

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0]    m_sticky, m_code;
  int            m_count;
  logic          m_fv, m_irq, m_js, m_ev, m_init;
  logic [W-1:0]  m_bus;
  logic [ND-1:0] m_ena;
  logic [2:0]    m_exp;

  datapath_monitor #(.WIDTH(W), .NUM_DRIVERS(ND), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .bus(bus),
    .drv_ena(drv_ena), .drv_data(drv_data), .flag_we(flag_we),
    .n(n), .z(z), .p(p), .err_sticky(err_sticky), .err_count(err_count),
    .first_valid(first_valid), .first_code(first_code), .first_bus(first_bus),
    .first_ena(first_ena), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] nzp_of(input logic [W-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0)         return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_sticky = 0; m_code = 0; m_count = 0; m_fv = 0; m_irq = 0; m_js = 0;
    m_ev = 0; m_init = 0; m_bus = 0; m_ena = 0; m_exp = 0;
  endtask

  // Apply one clock edge to the model using the inputs present at the edge
  task automatic model_edge();
    logic [3:0] c;
    logic [2:0] nzp;
    int ones;
    logic [W-1:0] sel;
    nzp = {n, z, p};
    ones = $countones(drv_ena);
    sel = '0;
    for (int i = 0; i < ND; i++) if (drv_ena[i]) sel = drv_data[i*W +: W];
    c[0] = mon_en && ones > 1;
    c[1] = mon_en && ones == 1 && bus != sel;
    c[2] = mon_en && m_ev && nzp != m_exp;
    c[3] = mon_en && ($countones(nzp) > 1 || (m_init && nzp == 3'b000));
    if (clr) begin
      model_reset();
    end else begin
      m_irq = m_js;
      m_js  = (c != 0) && !m_fv;
      if (c != 0) begin
        m_sticky |= c;
        if (m_count < MAXC) m_count++;
        if (!m_fv) begin m_fv = 1; m_code = c; m_bus = bus; m_ena = drv_ena; end
      end
      if (mon_en && flag_we) begin m_exp = nzp_of(bus); m_ev = 1; m_init = 1; end
      else m_ev = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sticky"}, err_sticky, m_sticky);
    chk({tag, ".count"},  err_count,  m_count);
    chk({tag, ".fvalid"}, first_valid, m_fv);
    chk({tag, ".fcode"},  first_code, m_code);
    chk({tag, ".fbus"},   first_bus,  m_bus);
    chk({tag, ".fena"},   first_ena,  m_ena);
    chk({tag, ".irq"},    err_irq,    m_irq);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_nzp(input logic [2:0] v);
    {n, z, p} = v;
  endtask

  initial begin
    model_reset();
    rst_n = 0; mon_en = 0; clr = 0; flag_we = 0; bus = 0; drv_ena = 0; drv_data = 0;
    set_nzp(3'b000);
    #12;
    check_all("reset");
    rst_n = 1; mon_en = 1;

    // legal single driver for 10 cycles
    drv_ena = 4'b0010; drv_data[1*W +: W] = 16'h1234; bus = 16'h1234;
    for (int i = 0; i < 10; i++) step("good");
    chk("good.sticky_k", err_sticky, 4'b0000);
    chk("good.count_k", err_count, 8'd0);

    // contention for one cycle
    drv_ena = 4'b0101; bus = 16'h0000;
    step("multi");
    chk("multi.sticky_k", err_sticky, 4'b0001);
    chk("multi.fena_k", first_ena, 4'b0101);
    chk("multi.irq_k0", err_irq, 1'b0);
    drv_ena = 4'b0010; bus = 16'h1234;
    step("multi+1");
    chk("multi.irq_k1", err_irq, 1'b1);
    step("multi+2");
    chk("multi.irq_k2", err_irq, 1'b0);

    // clear, then bus mismatch for 3 cycles
    clr = 1; step("clr1"); clr = 0;
    drv_ena = 4'b1000; drv_data[3*W +: W] = 16'h00FF; bus = 16'h00FE;
    repeat (3) step("busmis");
    chk("busmis.sticky_k", err_sticky, 4'b0010);
    chk("busmis.count_k", err_count, 8'd3);
    chk("busmis.fbus_k", first_bus, 16'h00FE);

    // negative write, wrong flags shown next cycle
    clr = 1; drv_ena = 0; step("clr2"); clr = 0;
    flag_we = 1; bus = 16'h8000; step("fw_neg");
    flag_we = 0; bus = 16'h0; set_nzp(3'b001); step("fw_neg_cmp");
    chk("fw_neg.sticky_k", err_sticky, 4'b0100);
    step("fw_neg_after");
    chk("fw_neg.count_k", err_count, 8'd1);

    // zero write, correct flags
    clr = 1; step("clr3"); clr = 0;
    flag_we = 1; bus = 16'h0000; step("fw_zero");
    flag_we = 0; set_nzp(3'b010); step("fw_zero_cmp");
    chk("fw_zero.sticky_k", err_sticky, 4'b0000);
    set_nzp(3'b000); step("nzp_none");
    chk("nzp_none.sticky_k", err_sticky, 4'b1000);
    set_nzp(3'b110); step("nzp_two");
    chk("nzp_two.count_k", err_count, 8'd2);
    set_nzp(3'b010);

    // saturation
    clr = 1; step("clr4"); clr = 0;
    drv_ena = 4'b0011;
    for (int i = 0; i < 300; i++) step("sat");
    chk("sat.count_k", err_count, 8'd255);
    clr = 1; step("clr_fire"); clr = 0;
    chk("clr_fire.count_k", err_count, 8'd0);
    chk("clr_fire.fvalid_k", first_valid, 1'b0);
    repeat (3) step("pre_rst");
    rst_n = 0; #1;
    model_reset();
    check_all("midrst");
    chk("midrst.count_k", err_count, 8'd0);
    #2 rst_n = 1; drv_ena = 0;

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      int r;
      mon_en = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 59) == 0);
      for (int d = 0; d < ND; d++) drv_data[d*W +: W] = W'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      drv_ena = ND'(1 << $urandom_range(0, ND-1));
      else if (r < 8) drv_ena = '0;
      else            drv_ena = ND'($urandom);
      bus = W'($urandom);
      if ($countones(drv_ena) == 1 && $urandom_range(0, 4) != 0)
        for (int d = 0; d < ND; d++) if (drv_ena[d]) bus = drv_data[d*W +: W];
      if ($urandom_range(0, 7) == 0) bus = '0;
      flag_we = ($urandom_range(0, 2) == 0);
      if (m_ev && $urandom_range(0, 6) != 0) set_nzp(m_exp);
      else if ($urandom_range(0, 5) != 0) set_nzp(3'(1 << $urandom_range(0, 2)));
      else set_nzp(3'($urandom));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
